// File: rtl/tcm_boot_loader.sv
// -----------------------------------------------------------------------------
// tcm_boot_loader
// Loads the SCR1 tightly-coupled memory from a byte stream and holds the core
// in reset until the image has been written and its checksum verified.
//
// Stream: 4 length bytes (word count L, little-endian), 4*L payload bytes
// (little-endian words, first byte lands in [7:0]), 1 checksum byte equal to
// the XOR of all payload bytes (0x00 when L = 0).
//
// Ports:
//   clk_i         system clock
//   rstn_i        synchronous active-low reset
//   start_i       begin a load (pulse or level), ignored while busy
//   byte_valid_i  byte_data_i carries a stream byte
//   byte_data_i   stream byte
//   byte_ready_o  loader accepts a byte this cycle
//   tcm_we_o      TCM write request, held until tcm_gnt_i
//   tcm_addr_o    TCM word address
//   tcm_wdata_o   TCM write data
//   tcm_gnt_i     TCM write accepted this cycle
//   core_rstn_o   active-low reset to the SCR1 core, released only in DONE
//   busy_o        load in progress
//   done_o        image loaded and verified
//   err_o         00 none, 01 length overflow, 10 checksum mismatch
//   words_o       words written so far
// -----------------------------------------------------------------------------
module tcm_boot_loader #(
  parameter int ADDR_W    = 14,
  parameter int MEM_WORDS = 16384,
  parameter int BASE_WORD = 0
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              tcm_we_o,
  output logic [ADDR_W-1:0] tcm_addr_o,
  output logic [31:0]       tcm_wdata_o,
  input  logic              tcm_gnt_i,
  output logic              core_rstn_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        err_o,
  output logic [ADDR_W:0]   words_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  localparam logic [33:0]       LP_BASE_W = 34'(BASE_WORD);
  localparam logic [33:0]       LP_MEM_W  = 34'(MEM_WORDS);
  localparam logic [ADDR_W-1:0] LP_BASE_A = ADDR_W'(BASE_WORD);

  // Running checksum update: plain 8-bit XOR, no carry.
  function automatic logic [7:0] f_csum_upd(input logic [7:0] csum, input logic [7:0] b);
    f_csum_upd = csum ^ b;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_len;
  logic [1:0]        r_cnt;
  logic [7:0]        r_csum;
  logic [31:0]       r_word;
  logic [ADDR_W:0]   r_words;
  logic [1:0]        r_err;

  logic              r_byte_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_core_rstn;
  logic              r_busy;
  logic              r_done;

  logic              w_xfer;
  logic              w_start_ok;
  logic [31:0]       w_len_full;
  logic [31:0]       w_word_full;
  logic              w_len_ovf;
  logic [ADDR_W:0]   w_words_inc;
  logic              w_last_word;

  logic              w_ready_nxt;
  logic              w_we_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [31:0]       w_wdata_nxt;
  logic              w_core_rstn_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;

  assign w_xfer      = byte_valid_i & r_byte_ready;
  assign w_start_ok  = start_i & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR));
  // Bytes shift in from the top, so after four transfers the first byte sits in [7:0].
  assign w_len_full  = {byte_data_i, r_len[31:8]};
  assign w_word_full = {byte_data_i, r_word[31:8]};
  // 34-bit sum so a 32-bit length plus base can never wrap before the compare.
  assign w_len_ovf   = (({2'b00, w_len_full} + LP_BASE_W) > LP_MEM_W);
  assign w_words_inc = r_words + {{ADDR_W{1'b0}}, 1'b1};
  assign w_last_word = ({{(31-ADDR_W){1'b0}}, w_words_inc} == r_len);

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          w_state_nxt = S_LEN;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_LEN: begin
        if (w_xfer && (r_cnt == 2'd3)) begin
          if (w_len_ovf) begin
            w_state_nxt = S_ERR;
          end else if (w_len_full == 32'd0) begin
            w_state_nxt = S_CSUM;
          end else begin
            w_state_nxt = S_DATA;
          end
        end else begin
          w_state_nxt = S_LEN;
        end
      end
      S_DATA: begin
        if (w_xfer && (r_cnt == 2'd3)) begin
          w_state_nxt = S_WRITE;
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      S_WRITE: begin
        if (tcm_gnt_i) begin
          w_state_nxt = w_last_word ? S_CSUM : S_DATA;
        end else begin
          w_state_nxt = S_WRITE;
        end
      end
      S_CSUM: begin
        if (w_xfer) begin
          w_state_nxt = (byte_data_i == r_csum) ? S_DONE : S_ERR;
        end else begin
          w_state_nxt = S_CSUM;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered outputs, derived from the next state.
  always_comb begin
    w_ready_nxt     = (w_state_nxt == S_LEN) | (w_state_nxt == S_DATA) | (w_state_nxt == S_CSUM);
    w_we_nxt        = (w_state_nxt == S_WRITE);
    w_busy_nxt      = w_ready_nxt | (w_state_nxt == S_WRITE);
    w_done_nxt      = (w_state_nxt == S_DONE);
    w_core_rstn_nxt = (w_state_nxt == S_DONE);
    // Address and data are captured on entry to WRITE and held until the grant.
    if ((r_state == S_DATA) && (w_state_nxt == S_WRITE)) begin
      w_addr_nxt  = LP_BASE_A + r_words[ADDR_W-1:0];
      w_wdata_nxt = w_word_full;
    end else begin
      w_addr_nxt  = r_addr;
      w_wdata_nxt = r_wdata;
    end
  end

  // Output registers.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_byte_ready <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= {ADDR_W{1'b0}};
      r_wdata      <= 32'd0;
      r_core_rstn  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_byte_ready <= w_ready_nxt;
      r_we         <= w_we_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_core_rstn  <= w_core_rstn_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
    end
  end

  // Datapath: length, byte counter, word assembly, checksum, word count, error code.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_len   <= 32'd0;
      r_cnt   <= 2'd0;
      r_csum  <= 8'd0;
      r_word  <= 32'd0;
      r_words <= {(ADDR_W+1){1'b0}};
      r_err   <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (w_start_ok) begin
            r_len   <= 32'd0;
            r_cnt   <= 2'd0;
            r_csum  <= 8'd0;
            r_words <= {(ADDR_W+1){1'b0}};
            r_err   <= 2'b00;
          end else begin
            r_err   <= r_err;
          end
        end
        S_LEN: begin
          if (w_xfer) begin
            r_len <= w_len_full;
            r_cnt <= r_cnt + 2'd1;
            if ((r_cnt == 2'd3) && w_len_ovf) begin
              r_err <= 2'b01;
            end else begin
              r_err <= r_err;
            end
          end else begin
            r_len <= r_len;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_word <= w_word_full;
            r_csum <= f_csum_upd(r_csum, byte_data_i);
            r_cnt  <= r_cnt + 2'd1;
          end else begin
            r_word <= r_word;
          end
        end
        S_WRITE: begin
          if (tcm_gnt_i) begin
            r_words <= w_words_inc;
          end else begin
            r_words <= r_words;
          end
        end
        S_CSUM: begin
          if (w_xfer && (byte_data_i != r_csum)) begin
            r_err <= 2'b10;
          end else begin
            r_err <= r_err;
          end
        end
        default: r_err <= r_err;
      endcase
    end
  end

  assign byte_ready_o = r_byte_ready;
  assign tcm_we_o     = r_we;
  assign tcm_addr_o   = r_addr;
  assign tcm_wdata_o  = r_wdata;
  assign core_rstn_o  = r_core_rstn;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign err_o        = r_err;
  assign words_o      = r_words;

endmodule

// File: tb/tb_tcm_boot_loader.sv
module tb_tcm_boot_loader;
  localparam int ADDR_W    = 14;
  localparam int MEM_WORDS = 16384;
  localparam int BASE_WORD = 0;

  logic              clk_i = 1'b0;
  logic              rstn_i;
  logic              start_i;
  logic              byte_valid_i;
  logic [7:0]        byte_data_i;
  logic              byte_ready_o;
  logic              tcm_we_o;
  logic [ADDR_W-1:0] tcm_addr_o;
  logic [31:0]       tcm_wdata_o;
  logic              tcm_gnt_i;
  logic              core_rstn_o;
  logic              busy_o;
  logic              done_o;
  logic [1:0]        err_o;
  logic [ADDR_W:0]   words_o;

  int checks = 0;
  int errors = 0;

  // Image to load (reference words) and observed TCM writes.
  logic [31:0]       img[$];
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];

  // gnt control and write-hold tracking.
  bit                gnt_stall = 1'b0;
  int                stall_cnt = 0;
  logic [ADDR_W-1:0] hold_addr;
  logic [31:0]       hold_data;

  tcm_boot_loader #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .BASE_WORD(BASE_WORD)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i),
    .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i), .byte_ready_o(byte_ready_o),
    .tcm_we_o(tcm_we_o), .tcm_addr_o(tcm_addr_o), .tcm_wdata_o(tcm_wdata_o),
    .tcm_gnt_i(tcm_gnt_i), .core_rstn_o(core_rstn_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .words_o(words_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory-side observer: record every accepted write.
  always @(posedge clk_i) begin
    if (rstn_i && tcm_we_o && tcm_gnt_i) begin
      wr_addr_q.push_back(tcm_addr_o);
      wr_data_q.push_back(tcm_wdata_o);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, then drive tcm_gnt_i and check write holding.
  task automatic cycle();
    @(negedge clk_i);
    if (tcm_we_o) begin
      if (stall_cnt == 0) begin
        hold_addr = tcm_addr_o;
        hold_data = tcm_wdata_o;
      end else begin
        chk("hold_addr", 64'(tcm_addr_o), 64'(hold_addr));
        chk("hold_data", 64'(tcm_wdata_o), 64'(hold_data));
        chk("hold_ready", 64'(byte_ready_o), 64'd0);
      end
      stall_cnt++;
      tcm_gnt_i = gnt_stall ? (stall_cnt >= 4) : 1'b1;
    end else begin
      if (stall_cnt != 0) begin
        chk("we_pulse_len", 64'(stall_cnt), gnt_stall ? 64'd4 : 64'd1);
      end
      stall_cnt = 0;
      tcm_gnt_i = ~gnt_stall;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int  t = 0;
    int  g = 0;
    bit  acc = 1'b0;
    if (gaps) begin
      while (($urandom_range(1, 0) == 0) && (g < 8)) begin
        cycle();
        g++;
      end
    end
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    while (!acc && (t < 200)) begin
      acc = byte_ready_o;
      cycle();
      t++;
    end
    byte_valid_i = 1'b0;
    if (!acc) chk("byte_accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic do_start();
    start_i = 1'b1;
    cycle();
    start_i = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy_o && (t < 200)) begin
      cycle();
      t++;
    end
    chk("idle_timeout", 64'(busy_o), 64'd0);
  endtask

  // Reference checksum: XOR all words together, then fold the four bytes.
  function automatic logic [7:0] ref_csum(input int n);
    logic [31:0] x = 32'd0;
    for (int i = 0; i < n; i++) x = x ^ img[i];
    return x[7:0] ^ x[15:8] ^ x[23:16] ^ x[31:24];
  endfunction

  task automatic run_load(input logic [31:0] len, input logic [7:0] cs_flip, input bit gaps);
    logic [31:0] w;
    do_start();
    for (int k = 0; k < 4; k++) send_byte(len[8*k +: 8], gaps);
    if (len <= 32'(MEM_WORDS - BASE_WORD)) begin
      for (int i = 0; i < int'(len); i++) begin
        w = img[i];
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
        chk("we_latency", 64'(tcm_we_o), 64'd1);
      end
      send_byte(ref_csum(int'(len)) ^ cs_flip, gaps);
    end
    wait_idle();
  endtask

  task automatic check_result(input string tag, input logic [31:0] len, input logic [1:0] exp_err, input int wr_start);
    int n;
    chk({tag, "_err"}, 64'(err_o), 64'(exp_err));
    chk({tag, "_done"}, 64'(done_o), (exp_err == 2'b00) ? 64'd1 : 64'd0);
    chk({tag, "_core_rstn"}, 64'(core_rstn_o), (exp_err == 2'b00) ? 64'd1 : 64'd0);
    n = (exp_err == 2'b01) ? 0 : int'(len);
    chk({tag, "_words"}, 64'(words_o), 64'(n));
    chk({tag, "_nwrites"}, 64'(wr_addr_q.size() - wr_start), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (wr_start + i < wr_addr_q.size()) begin
        chk({tag, "_addr"}, 64'(wr_addr_q[wr_start + i]), 64'((BASE_WORD + i) % (1 << ADDR_W)));
        chk({tag, "_data"}, 64'(wr_data_q[wr_start + i]), 64'(img[i]));
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, 64'(byte_ready_o), 64'd0);
    chk({tag, "_we"}, 64'(tcm_we_o), 64'd0);
    chk({tag, "_addr"}, 64'(tcm_addr_o), 64'd0);
    chk({tag, "_wdata"}, 64'(tcm_wdata_o), 64'd0);
    chk({tag, "_core_rstn"}, 64'(core_rstn_o), 64'd0);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_done"}, 64'(done_o), 64'd0);
    chk({tag, "_err"}, 64'(err_o), 64'd0);
    chk({tag, "_words"}, 64'(words_o), 64'd0);
  endtask

  initial begin
    int ws;
    rstn_i       = 1'b0;
    start_i      = 1'b0;
    byte_valid_i = 1'b0;
    byte_data_i  = 8'h00;
    tcm_gnt_i    = 1'b1;

    // Reset state.
    repeat (3) cycle();
    check_reset_vals("rst");
    rstn_i = 1'b1;
    cycle();

    // Two-word directed image, gnt tied high.
    img = '{32'h0000_0013, 32'h0000_006F};
    chk("csum_ref", 64'(ref_csum(2)), 64'h7C);
    ws = wr_addr_q.size();
    run_load(32'd2, 8'h00, 1'b0);
    check_result("basic", 32'd2, 2'b00, ws);

    // Same image with gnt held low 3 cycles on every write.
    gnt_stall = 1'b1;
    ws = wr_addr_q.size();
    run_load(32'd2, 8'h00, 1'b0);
    check_result("stall", 32'd2, 2'b00, ws);
    gnt_stall = 1'b0;
    cycle();

    // Wrong checksum (0x7D), then a correct reload.
    ws = wr_addr_q.size();
    run_load(32'd2, 8'h01, 1'b0);
    check_result("badcs", 32'd2, 2'b10, ws);
    ws = wr_addr_q.size();
    run_load(32'd2, 8'h00, 1'b0);
    check_result("reload", 32'd2, 2'b00, ws);

    // Length overflow (0x4001) and zero-length image.
    ws = wr_addr_q.size();
    run_load(32'h0000_4001, 8'h00, 1'b0);
    check_result("ovf", 32'h0000_4001, 2'b01, ws);
    ws = wr_addr_q.size();
    run_load(32'd0, 8'h00, 1'b0);
    check_result("zero", 32'd0, 2'b00, ws);

    // Reset after the 2nd payload byte of word 1.
    img = '{32'h0000_0013, 32'h0000_006F};
    do_start();
    send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h6F, 1'b0); send_byte(8'h00, 1'b0);
    chk("midload_busy", 64'(busy_o), 64'd1);
    rstn_i = 1'b0;
    cycle();
    rstn_i = 1'b1;
    check_reset_vals("midrst");
    cycle();
    chk("midrst_idle_busy", 64'(busy_o), 64'd0);
    img.delete();
    for (int i = 0; i < 3; i++) img.push_back($urandom());
    ws = wr_addr_q.size();
    run_load(32'd3, 8'h00, 1'b0);
    check_result("after_rst", 32'd3, 2'b00, ws);

    // 16 random words with random byte_valid_i gaps.
    img.delete();
    for (int i = 0; i < 16; i++) img.push_back($urandom());
    ws = wr_addr_q.size();
    run_load(32'd16, 8'h00, 1'b1);
    check_result("rand16", 32'd16, 2'b00, ws);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
